// File: rtl/layer_serializer.sv
// -----------------------------------------------------------------------------
// layer_serializer
//   Captures one complete layer result (all neuron outputs valid together) and
//   replays it as a gap-free stream of numNeurons words, one per clock, to feed
//   the next layer's single-input neuron port.
//
// Ports
//   clk          : clock, all state changes on the rising edge
//   rst          : synchronous active-high reset
//   in_data      : neuron k output at in_data[k*dataWidth +: dataWidth]
//   in_valid     : bit k is neuron k output-valid
//   out_data     : serialized word (zero while idle)
//   out_valid    : out_data carries a word this cycle
//   out_last     : current word is neuron numNeurons-1
//   busy         : a stream is being emitted
//   err_overrun  : sticky, a capture arrived mid-stream and was dropped
//   err_mismatch : sticky, in_valid was seen partially set
// -----------------------------------------------------------------------------
module layer_serializer #(
    parameter int numNeurons = 30,
    parameter int dataWidth  = 16,
    parameter int cntWidth   = $clog2(numNeurons) + 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [numNeurons*dataWidth-1:0] in_data,
    input  logic [numNeurons-1:0]           in_valid,
    output logic [dataWidth-1:0]            out_data,
    output logic                            out_valid,
    output logic                            out_last,
    output logic                            busy,
    output logic                            err_overrun,
    output logic                            err_mismatch
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [cntWidth-1:0] LAST_IDX = cntWidth'(numNeurons - 1);
    localparam logic [cntWidth-1:0] ZERO_IDX = {cntWidth{1'b0}};

    state_t               state_r;
    logic [cntWidth-1:0]  cnt_r;
    logic [dataWidth-1:0] cap_r [numNeurons];

    logic                 capture_s;
    logic                 partial_s;
    logic                 load_s;
    logic                 overrun_s;
    logic [cntWidth-1:0]  cnt_nxt_s;
    logic [dataWidth-1:0] next_word_s;

    // Classify in_valid and decide whether this edge starts a new stream.
    // A capture is accepted when idle or while the last word is showing, so
    // consecutive streams abut with no gap.
    always_comb begin
        capture_s = &in_valid;
        partial_s = (|in_valid) && !capture_s;
        load_s    = capture_s && ((state_r == IDLE) || (cnt_r == LAST_IDX));
        overrun_s = capture_s && (state_r == SHIFT) && (cnt_r != LAST_IDX);
        cnt_nxt_s = cnt_r + cntWidth'(1);
    end

    // Select the next captured word by comparison rather than direct indexing,
    // because the counter is one bit wider than the array index.
    always_comb begin
        next_word_s = {dataWidth{1'b0}};
        for (int k = 0; k < numNeurons; k++) begin
            if (cnt_nxt_s == cntWidth'(k)) begin
                next_word_s = cap_r[k];
            end else begin
                next_word_s = next_word_s;
            end
        end
    end

    // Capture register; no reset needed since its contents only reach the
    // output while shifting, and shifting always begins with a fresh load.
    always_ff @(posedge clk) begin
        if (load_s && !rst) begin
            for (int k = 0; k < numNeurons; k++) begin
                cap_r[k] <= in_data[k*dataWidth +: dataWidth];
            end
        end
    end

    // Control FSM with registered outputs. Word 0 is taken straight from
    // in_data on the load edge so it appears in the very next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= ZERO_IDX;
            out_data     <= {dataWidth{1'b0}};
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            busy         <= 1'b0;
            err_overrun  <= 1'b0;
            err_mismatch <= 1'b0;
        end else begin
            if (partial_s) begin
                err_mismatch <= 1'b1;
            end
            if (overrun_s) begin
                err_overrun <= 1'b1;
            end

            if (load_s) begin
                state_r   <= SHIFT;
                cnt_r     <= ZERO_IDX;
                out_data  <= in_data[dataWidth-1:0];
                out_valid <= 1'b1;
                out_last  <= (LAST_IDX == ZERO_IDX);
                busy      <= 1'b1;
            end else begin
                case (state_r)
                    SHIFT: begin
                        if (cnt_r == LAST_IDX) begin
                            state_r   <= IDLE;
                            cnt_r     <= ZERO_IDX;
                            out_data  <= {dataWidth{1'b0}};
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                        end else begin
                            cnt_r     <= cnt_nxt_s;
                            out_data  <= next_word_s;
                            out_valid <= 1'b1;
                            out_last  <= (cnt_nxt_s == LAST_IDX);
                            busy      <= 1'b1;
                        end
                    end
                    IDLE: begin
                        state_r   <= IDLE;
                        cnt_r     <= ZERO_IDX;
                        out_data  <= {dataWidth{1'b0}};
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        busy      <= 1'b0;
                    end
                    default: begin
                        state_r   <= IDLE;
                        cnt_r     <= ZERO_IDX;
                        out_data  <= {dataWidth{1'b0}};
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/layer_serializer.md
LAYER_SERIALIZER -- requirements
Module: layer_serializer

Interface
REQ-001 SHALL have parameter numNeurons, default 30, meaning the number of neuron outputs captured per layer result.
REQ-002 SHALL have parameter dataWidth, default 16, meaning the width of each neuron output word.
REQ-003 SHALL have parameter cntWidth, default $clog2(numNeurons)+1, meaning the output word counter width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port in_data, input, numNeurons*dataWidth bits: neuron k output at in_data[k*dataWidth +: dataWidth].
REQ-007 SHALL have port in_valid, input, numNeurons bits: bit k is neuron k outvalid.
REQ-008 SHALL have port out_data, output, dataWidth bits: serialized word, which drives next-layer neuron myinput.
REQ-009 SHALL have port out_valid, output, 1 bit: out_data is valid this cycle, which drives next-layer myinputValid.
REQ-010 SHALL have port out_last, output, 1 bit: the current word is neuron numNeurons-1.
REQ-011 SHALL have port busy, output, 1 bit: state is SHIFT.
REQ-012 SHALL have port err_overrun, output, 1 bit: sticky flag set when a capture is dropped.
REQ-013 SHALL have port err_mismatch, output, 1 bit: sticky flag set on partial in_valid.

Function
REQ-014 SHALL implement states IDLE and SHIFT, plus an internal capture register of numNeurons words and a word counter cnt.
REQ-015 SHALL define a capture event as the AND of all in_valid bits being 1 at a rising edge.
REQ-016 On a capture event in IDLE, SHALL:
- load all words into the capture register,
- set cnt=0,
- go to SHIFT.
REQ-017 In SHIFT, SHALL each cycle:
- drive out_valid=1,
- drive out_data = captured word cnt,
- increment cnt.
REQ-018 SHALL emit exactly numNeurons consecutive valid words, in order 0..numNeurons-1, with no gaps; there is no backpressure.
REQ-019 SHALL have a latency of 1 cycle: the first word appears in the cycle after the capture edge.
REQ-020 SHALL assert out_last=1 only together with out_valid when cnt==numNeurons-1.
REQ-021 On the out_last cycle, SHALL return to IDLE when there is no capture event.
REQ-022 On a capture event in the out_last cycle, SHALL:
- accept it,
- reload the capture register,
- set cnt=0,
- stay in SHIFT,
so that streams run back-to-back with zero gap.
REQ-023 On a capture event in SHIFT with cnt<numNeurons-1, SHALL:
- drop the new data,
- leave the stream in progress unaltered,
- set err_overrun=1.
REQ-024 When in_valid is nonzero but not all ones at an edge, SHALL:
- set err_mismatch=1,
- capture nothing.
- This applies in any state.
REQ-025 SHALL hold err_overrun and err_mismatch until rst; no other event clears them.
REQ-026 In IDLE, SHALL drive out_valid=0, out_last=0, and out_data = all zeros.
REQ-027 SHALL drive all outputs directly from registers, with no combinational path from inputs to outputs.
REQ-028 SHALL pass words through bit-exact, with no sign or width transformation.
REQ-029 Under numNeurons=1, SHALL produce one word per capture, with out_valid and out_last asserted together.

Reset
REQ-030 When rst=1 at an edge, SHALL set:
- state to IDLE,
- cnt=0,
- out_valid=0, out_last=0, busy=0,
- out_data=0,
- err_overrun=0, err_mismatch=0.
REQ-031 A rst asserted mid-stream SHALL abort the stream; no further words are emitted.
REQ-032 A capture event coincident with rst SHALL be ignored.
REQ-033 Capture register contents SHALL need no reset, because they are never visible while in IDLE.

Verification (numNeurons=4, dataWidth=16)
REQ-034 SHALL cover the basic stream:
- Stimulus: in_valid=4'b1111 for one cycle, with words 0x0011, 0x0022, 0x0033, 0x0044.
- Response: out_valid high for 4 cycles starting next cycle; data 0x0011, 0x0022, 0x0033, 0x0044; out_last only on 0x0044; busy=0 after.
REQ-035 SHALL cover back-to-back streams:
- Stimulus: a second capture with 0xA000..0xA003, coincident with the out_last cycle of the first stream.
- Response: 8 contiguous valid cycles; out_last on cycles 4 and 8.
REQ-036 SHALL cover overrun:
- Stimulus: a capture with 0xBEEF words on stream cycle 2.
- Response: the original 4 words complete unaltered; err_overrun=1 and it stays 1; no 0xBEEF words are ever output.
REQ-037 SHALL cover mismatch:
- Stimulus: in_valid=4'b0101.
- Response: err_mismatch=1; out_valid stays 0; busy stays 0.
REQ-038 SHALL cover reset mid-stream:
- Stimulus: rst=1 on stream cycle 2.
- Response: next cycle out_valid=0, out_data=0, both err flags 0; a new capture afterwards streams normally from word 0.
